lc3_mem_arbiter: RTL and testbench

LC3_MEM_ARBITER -- requirements
Module: lc3_mem_arbiter

---
 rtl/lc3_mem_arbiter_if.sv | 47 ++++
 rtl/lc3_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the memory.
interface lc3_mem_arbiter_if;
    localparam int unsigned DATA_W = 16;

    logic              cpu_req;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [DATA_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_done;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_lock;

    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_done, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output dma_gnt, dma_done, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_done, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  dma_gnt, dma_done, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Two-requester (CPU, DMA) single-port memory arbiter with round-robin
// tie-break and a bounded DMA lock; every access occupies IDLE/ACCESS/DONE.
module lc3_mem_arbiter #(
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    lc3_mem_arbiter_if.slave bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LOCK_W = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic                own_q, own_d;      // 1 = DMA owns the current access
    logic                last_q, last_d;    // 1 = DMA was served last
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic                cpu_gnt_q, cpu_gnt_d;
    logic                dma_gnt_q, dma_gnt_d;
    logic                cpu_done_q, cpu_done_d;
    logic                dma_done_q, dma_done_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
    logic                lock_ok_c;
    logic                pick_dma_c;

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            own_q       <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lock_q      <= '0;
            cpu_gnt_q   <= 1'b0;
            dma_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lock_q      <= lock_d;
            cpu_gnt_q   <= cpu_gnt_d;
            dma_gnt_q   <= dma_gnt_d;
            cpu_done_q  <= cpu_done_d;
            dma_done_q  <= dma_done_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Lock override holds DMA only while it was last owner and under budget
    assign lock_ok_c  = last_q && bus.dma_lock && (lock_q < LOCK_W'(MAX_LOCK));
    assign pick_dma_c = bus.dma_req && (!bus.cpu_req || !last_q || lock_ok_c);

    // Next-state, arbitration and next output values
    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lock_d      = lock_q;
        cpu_gnt_d   = 1'b0;
        dma_gnt_d   = 1'b0;
        cpu_done_d  = 1'b0;
        dma_done_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        case (state_q)
            IDLE: begin
                if (!bus.dma_lock) begin
                    lock_d = '0;
                end
                if (bus.cpu_req || bus.dma_req) begin
                    state_d   = ACCESS;
                    own_d     = pick_dma_c;
                    last_d    = pick_dma_c;
                    we_d      = pick_dma_c ? bus.dma_we    : bus.cpu_we;
                    addr_d    = pick_dma_c ? bus.dma_addr  : bus.cpu_addr;
                    wdata_d   = pick_dma_c ? bus.dma_wdata : bus.cpu_wdata;
                    cpu_gnt_d = !pick_dma_c;
                    dma_gnt_d = pick_dma_c;
                    mem_en_d  = 1'b1;
                    mem_we_d  = pick_dma_c ? bus.dma_we : bus.cpu_we;
                    if (!pick_dma_c) begin
                        lock_d = '0;
                    end else if (bus.cpu_req && bus.dma_lock &&
                                 (lock_q < LOCK_W'(MAX_LOCK))) begin
                        lock_d = lock_q + LOCK_W'(1);
                    end
                end
            end
            ACCESS: begin
                state_d    = DONE;
                cpu_done_d = !own_q;
                dma_done_d = own_q;
            end
            DONE: begin
                state_d = IDLE;
                if (!we_q) begin
                    if (own_q) dma_rdata_d = bus.mem_rdata;
                    else       cpu_rdata_d = bus.mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cpu_gnt   = cpu_gnt_q;
    assign bus.dma_gnt   = dma_gnt_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.dma_done  = dma_done_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter with a grant-order scoreboard.
module tb_lc3_mem_arbiter;
    typedef struct packed {
        logic        own;   // 1 = DMA
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    txn_t sb[$];

    lc3_mem_arbiter_if bus();

    lc3_mem_arbiter #(.MAX_LOCK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_model(input logic [15:0] a);
        return a ^ 16'h8EEF;
    endfunction

    function automatic txn_t mk(input logic own, input logic we,
                                input logic [15:0] addr, input logic [15:0] wdata);
        txn_t t;
        t.own = own; t.we = we; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= rd_model(bus.mem_addr);
    end

    // Monitor: grant order/payload, done pulse timing, rdata update
    txn_t        p_t, s_t, g_t;
    logic        p_v = 1'b0, s_v = 1'b0;
    logic [15:0] m_cpu = '0, m_dma = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_v = 1'b0; s_v = 1'b0; m_cpu = '0; m_dma = '0;
        end else begin
            if (s_v) begin
                if (!s_t.we) begin
                    if (s_t.own) m_dma = rd_model(s_t.addr);
                    else         m_cpu = rd_model(s_t.addr);
                end
                if (s_t.own) chk("dma_rdata", bus.dma_rdata, m_dma);
                else         chk("cpu_rdata", bus.cpu_rdata, m_cpu);
                s_v = 1'b0;
            end
            if (p_v || bus.cpu_done || bus.dma_done) begin
                chk("cpu_done", 16'(bus.cpu_done), 16'(p_v && !p_t.own));
                chk("dma_done", 16'(bus.dma_done), 16'(p_v && p_t.own));
                if (p_v) begin s_v = 1'b1; s_t = p_t; end
                p_v = 1'b0;
            end
            if (bus.cpu_gnt || bus.dma_gnt) begin
                chk("gnt_exclusive", 16'(bus.cpu_gnt && bus.dma_gnt), 16'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_grant", 16'(bus.dma_gnt), 16'hFFFF);
                end else begin
                    g_t = sb.pop_front();
                    chk("grant_owner", 16'(bus.dma_gnt), 16'(g_t.own));
                    chk("mem_en", 16'(bus.mem_en), 16'd1);
                    chk("mem_we", 16'(bus.mem_we), 16'(g_t.we));
                    chk("mem_addr", bus.mem_addr, g_t.addr);
                    if (g_t.we) chk("mem_wdata", bus.mem_wdata, g_t.wdata);
                    p_v = 1'b1;
                    p_t = g_t;
                end
            end
        end
    end

    // Single access, request dropped on the done cycle
    task automatic access(input logic own, input logic we,
                          input logic [15:0] addr, input logic [15:0] wdata);
        sb.push_back(mk(own, we, addr, wdata));
        if (own) begin
            bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata; bus.dma_req = 1'b1;
        end else begin
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        if (own) bus.dma_req = 1'b0; else bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.dma_lock = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_gnt", 16'(bus.cpu_gnt), 16'd0);
        chk("rst_dma_gnt", 16'(bus.dma_gnt), 16'd0);
        chk("rst_done", 16'({bus.cpu_done, bus.dma_done}), 16'd0);
        chk("rst_mem_en", 16'({bus.mem_en, bus.mem_we}), 16'd0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
        chk("rst_cpu_rdata", bus.cpu_rdata, 16'h0000);
        chk("rst_dma_rdata", bus.dma_rdata, 16'h0000);
        rst_n = 1'b1;

        // Simultaneous requests after reset: CPU first, then DMA
        sb.push_back(mk(1'b0, 1'b0, 16'h1111, 16'h0));
        sb.push_back(mk(1'b1, 1'b0, 16'h2222, 16'h0));
        bus.cpu_addr = 16'h1111; bus.dma_addr = 16'h2222;
        bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
        @(posedge clk); #1;
        chk("tie_cpu_gnt", 16'({bus.cpu_gnt, bus.dma_gnt}), 16'b10);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("tie_idle_gap", 16'({bus.cpu_gnt, bus.dma_gnt}), 16'b00);
        @(posedge clk); #1;
        chk("tie_dma_gnt", 16'({bus.cpu_gnt, bus.dma_gnt}), 16'b01);
        @(posedge clk); #1;
        bus.dma_req = 1'b0;
        @(posedge clk); #1;

        // CPU read 0x3000 alone with exact latency; addr change ignored in ACCESS
        sb.push_back(mk(1'b0, 1'b0, 16'h3000, 16'h0));
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h3000; bus.cpu_req = 1'b1;
        @(posedge clk); #1;
        chk("rd_gnt", 16'(bus.cpu_gnt), 16'd1);
        chk("rd_addr", bus.mem_addr, 16'h3000);
        bus.cpu_addr = 16'h5555;
        @(posedge clk); #1;
        chk("rd_done", 16'(bus.cpu_done), 16'd1);
        chk("rd_gnt_off", 16'({bus.cpu_gnt, bus.mem_en}), 16'd0);
        chk("rd_addr_held", bus.mem_addr, 16'h3000);
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("rd_rdata", bus.cpu_rdata, 16'hBEEF);

        // DMA write 0x4000 <= 0x1234, rdata untouched
        sb.push_back(mk(1'b1, 1'b1, 16'h4000, 16'h1234));
        bus.dma_we = 1'b1; bus.dma_addr = 16'h4000; bus.dma_wdata = 16'h1234; bus.dma_req = 1'b1;
        @(posedge clk); #1;
        chk("wr_we", 16'(bus.mem_we), 16'd1);
        chk("wr_wdata", bus.mem_wdata, 16'h1234);
        @(posedge clk); #1;
        chk("wr_we_off", 16'(bus.mem_we), 16'd0);
        chk("wr_done", 16'(bus.dma_done), 16'd1);
        bus.dma_req = 1'b0;
        @(posedge clk); #1;
        chk("wr_rdata_kept", bus.dma_rdata, 16'hACCD);

        // Lock: CPU served, then DMA x4 under lock, then CPU, then alternation
        access(1'b0, 1'b1, 16'h3100, 16'hAAAA);
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'h3100; bus.cpu_wdata = 16'hAAAA;
        bus.dma_we = 1'b0; bus.dma_addr = 16'h4100;
        bus.dma_lock = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(mk(1'b1, 1'b0, 16'h4100, 16'h0));
        sb.push_back(mk(1'b0, 1'b1, 16'h3100, 16'hAAAA));
        bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("lock_sb_drained", 16'(sb.size()), 16'd0);
        bus.dma_lock = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(1'b1, 1'b0, 16'h4100, 16'h0));
            sb.push_back(mk(1'b0, 1'b1, 16'h3100, 16'hAAAA));
        end
        repeat (12) @(posedge clk);
        #1;
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        @(posedge clk); #1;

        // Reset mid-access: grant and strobe drop at once, no done, rdata cleared
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h3000; bus.cpu_req = 1'b1;
        chk("pre_rst_rdata", bus.cpu_rdata, 16'hBEEF);
        sb.push_back(mk(1'b0, 1'b0, 16'h3000, 16'h0));
        @(posedge clk); #1;
        chk("mid_gnt", 16'(bus.cpu_gnt), 16'd1);
        void'(sb.pop_back());
        rst_n = 1'b0;
        #1;
        chk("rst_gnt_drop", 16'({bus.cpu_gnt, bus.mem_en}), 16'd0);
        chk("rst_rdata_clr", bus.cpu_rdata, 16'h0000);
        @(posedge clk); #1;
        chk("rst_no_done", 16'(bus.cpu_done), 16'd0);
        @(posedge clk); #1;
        sb.push_back(mk(1'b0, 1'b0, 16'h3000, 16'h0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_gnt", 16'(bus.cpu_gnt), 16'd1);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_rdata", bus.cpu_rdata, 16'hBEEF);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
